// File: rtl/gain_ramp.sv
// Output volume/mute stage: scales each sample by a gain that ramps linearly toward
// the target, so gain changes and mutes do not click. Two-stage multiply/saturate pipeline.
module gain_ramp #(
  parameter int          DATA_BIT = 16,
  parameter logic [15:0] STEP     = 16'h0010,
  parameter logic [15:0] MAX_GAIN = 16'h7FFF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DATA_BIT-1:0] i_audio,
  input  logic                i_audio_valid,
  input  logic [15:0]         i_gain,
  input  logic                i_mute,
  output logic [DATA_BIT-1:0] o_audio,
  output logic                o_audio_valid,
  output logic [15:0]         o_gain,
  output logic                o_ramping,
  output logic                o_muted
);
  localparam int PW = DATA_BIT + 17;
  localparam logic signed [PW-1:0] Y_MAX = $signed({{(PW-DATA_BIT+1){1'b0}}, {(DATA_BIT-1){1'b1}}});
  localparam logic signed [PW-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, MUTED} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                g_q, g_d;
  logic signed [PW-1:0]       p_q, p_d;
  logic [1:0]                 vld_pipe_q, vld_pipe_d;
  logic [DATA_BIT-1:0]        o_audio_q, o_audio_d;

  logic [15:0]                tgt;
  logic [16:0]                g_up, dn_lim;
  logic signed [PW-1:0]       a_ext, g_ext, y;

  // Gain ramp and state: both only move on an accepted sample.
  always_comb begin
    tgt     = i_mute ? 16'h0000 : ((i_gain > MAX_GAIN) ? MAX_GAIN : i_gain);
    g_up    = {1'b0, g_q} + {1'b0, STEP};
    dn_lim  = {1'b0, tgt} + {1'b0, STEP};
    g_d     = g_q;
    state_d = state_q;
    if (i_audio_valid) begin
      if (g_q < tgt)
        g_d = (g_up >= {1'b0, tgt}) ? tgt : g_up[15:0];
      else if (g_q > tgt)
        g_d = ({1'b0, g_q} <= dn_lim) ? tgt : (g_q - STEP);
      if (g_d == 16'h0000 && i_mute) state_d = MUTED;
      else if (g_d < tgt)            state_d = RAMP_UP;
      else if (g_d > tgt)            state_d = RAMP_DOWN;
      else                           state_d = IDLE;
    end
  end

  // The sample is scaled by the gain held before this strobe's update.
  always_comb begin
    a_ext      = {{(PW-DATA_BIT){i_audio[DATA_BIT-1]}}, i_audio};
    g_ext      = {{(PW-16){1'b0}}, g_q};
    p_d        = i_audio_valid ? (a_ext * g_ext) : p_q;
    vld_pipe_d = {vld_pipe_q[0], i_audio_valid};
    y          = p_q >>> 14;
    o_audio_d  = o_audio_q;
    if (vld_pipe_q[0]) begin
      if (y > Y_MAX)      o_audio_d = Y_MAX[DATA_BIT-1:0];
      else if (y < Y_MIN) o_audio_d = Y_MIN[DATA_BIT-1:0];
      else                o_audio_d = y[DATA_BIT-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      g_q        <= '0;
      p_q        <= '0;
      vld_pipe_q <= '0;
      o_audio_q  <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      p_q        <= p_d;
      vld_pipe_q <= vld_pipe_d;
      o_audio_q  <= o_audio_d;
    end
  end

  assign o_audio       = o_audio_q;
  assign o_audio_valid = vld_pipe_q[1];
  assign o_gain        = g_q;
  assign o_ramping     = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign o_muted       = (state_q == MUTED);
endmodule
